// File: rtl/multiplier_datapath_taint_track.sv
// Shift-add datapath for the sequential multiplier with conservative per-bit taint tracking.
// Holds md, mr and the 2*WIDTH+1 bit running sum rs; responds to controller strobes.
`timescale 1ns/1ps
module multiplier_datapath_taint_track #(
    parameter int WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplicand_t,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplier_t,
    input  logic                 rsload,
    input  logic                 rsload_t,
    input  logic                 rsclear,
    input  logic                 rsclear_t,
    input  logic                 rsshr,
    input  logic                 rsshr_t,
    input  logic                 mrld,
    input  logic                 mrld_t,
    input  logic                 mdld,
    input  logic                 mdld_t,
    input  logic                 data_t_kill,
    output logic [WIDTH-1:0]     multiplierReg,
    output logic [WIDTH-1:0]     multiplierReg_t,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   product_t
);

    localparam int RW = 2*WIDTH + 1;

    logic [WIDTH-1:0] md_q, md_d, md_t_q, md_t_d;
    logic [WIDTH-1:0] mr_q, mr_d, mr_t_q, mr_t_d;
    logic [RW-1:0]    rs_q, rs_d, rs_t_q, rs_t_d;

    logic [WIDTH:0]   rs_upper;
    logic [WIDTH:0]   rs_upper_t;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   load_t;

    assign rs_upper   = rs_q[2*WIDTH:WIDTH];
    assign rs_upper_t = rs_t_q[2*WIDTH:WIDTH];
    assign sum        = rs_upper + {1'b0, md_q};

    // Prefix-OR over both addends approximates how taint can ripple up the carry chain.
    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_load_t
            if (gi == 0) begin : g_first
                assign load_t[gi] = rs_upper_t[gi] | md_t_q[gi];
            end else if (gi < WIDTH) begin : g_mid
                assign load_t[gi] = load_t[gi-1] | rs_upper_t[gi] | md_t_q[gi];
            end else begin : g_carry
                assign load_t[gi] = load_t[gi-1] | rs_upper_t[gi];
            end
        end
    endgenerate

    always_comb begin
        md_d   = md_q;
        md_t_d = md_t_q;
        if (mdld) begin
            md_d   = multiplicand;
            md_t_d = multiplicand_t;
        end
        if (mdld_t) begin
            md_t_d = {WIDTH{1'b1}};
        end
        if (data_t_kill) begin
            md_t_d = '0;
        end
    end

    always_comb begin
        mr_d   = mr_q;
        mr_t_d = mr_t_q;
        if (mrld) begin
            mr_d   = multiplier;
            mr_t_d = multiplier_t;
        end
        if (mrld_t) begin
            mr_t_d = {WIDTH{1'b1}};
        end
        if (data_t_kill) begin
            mr_t_d = '0;
        end
    end

    always_comb begin
        rs_d   = rs_q;
        rs_t_d = rs_t_q;
        if (rsclear) begin
            rs_d   = '0;
            rs_t_d = '0;
        end else if (rsload) begin
            rs_d   = {sum, rs_q[WIDTH-1:0]};
            rs_t_d = {load_t, rs_t_q[WIDTH-1:0]};
        end else if (rsshr) begin
            rs_d   = rs_q >> 1;
            rs_t_d = rs_t_q >> 1;
        end
        // A tainted strobe means any rs update might or might not have happened.
        if (rsclear_t || rsload_t || rsshr_t) begin
            rs_t_d = {RW{1'b1}};
        end
        if (data_t_kill) begin
            rs_t_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_q   <= '0;
            md_t_q <= '0;
            mr_q   <= '0;
            mr_t_q <= '0;
            rs_q   <= '0;
            rs_t_q <= '0;
        end else begin
            md_q   <= md_d;
            md_t_q <= md_t_d;
            mr_q   <= mr_d;
            mr_t_q <= mr_t_d;
            rs_q   <= rs_d;
            rs_t_q <= rs_t_d;
        end
    end

    assign multiplierReg   = mr_q;
    assign multiplierReg_t = mr_t_q;
    assign product         = rs_q[2*WIDTH-1:0];
    assign product_t       = rs_t_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_datapath_taint_track.sv
// Self-checking bench for the taint-tracking multiplier datapath at WIDTH=4.
`timescale 1ns/1ps
module tb_multiplier_datapath_taint_track;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   multiplicand, multiplicand_t, multiplier, multiplier_t;
    logic           rsload, rsload_t, rsclear, rsclear_t, rsshr, rsshr_t;
    logic           mrld, mrld_t, mdld, mdld_t, data_t_kill;
    logic [W-1:0]   multiplierReg, multiplierReg_t;
    logic [2*W-1:0] product, product_t;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2*W-1:0] prod;
        logic [2*W-1:0] prod_t;
        logic [W-1:0]   mr;
        logic [W-1:0]   mr_t;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    multiplier_datapath_taint_track #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .multiplicand    (multiplicand),
        .multiplicand_t  (multiplicand_t),
        .multiplier      (multiplier),
        .multiplier_t    (multiplier_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .data_t_kill     (data_t_kill),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
        .product         (product),
        .product_t       (product_t)
    );

    task automatic clear_strobes();
        rsload = 0; rsload_t = 0; rsclear = 0; rsclear_t = 0;
        rsshr = 0; rsshr_t = 0; mrld = 0; mrld_t = 0;
        mdld = 0; mdld_t = 0; data_t_kill = 0;
    endtask

    // Strobes set before calling take effect at the next posedge; sampling is 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic start_mult(input logic [W-1:0] a, input logic [W-1:0] at,
                              input logic [W-1:0] b, input logic [W-1:0] bt);
        multiplicand = a; multiplicand_t = at;
        multiplier = b;   multiplier_t = bt;
        mdld = 1; mrld = 1; rsclear = 1;
        step();
        rsshr = 1;
        step();
    endtask

    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] at,
                            input logic [W-1:0] b, input logic [W-1:0] bt,
                            input logic [2*W-1:0] exp_pt);
        exp_t e;
        int p;
        p = int'(a) * int'(b);
        e.prod = p[2*W-1:0]; e.prod_t = exp_pt; e.mr = b; e.mr_t = bt;
        exp_q.push_back(e);
        start_mult(a, at, b, bt);
        for (int k = 0; k < W; k++) begin
            if (b[k]) begin
                rsload = 1;
                step();
            end
            rsshr = 1;
            step();
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s: scoreboard empty, got product=%h required an entry", name, product);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (product !== e.prod) begin
            errors++;
            $display("FAIL %s product: got %h required %h", name, product, e.prod);
        end
        checks++;
        if (product_t !== e.prod_t) begin
            errors++;
            $display("FAIL %s product_t: got %h required %h", name, product_t, e.prod_t);
        end
        checks++;
        if (multiplierReg !== e.mr) begin
            errors++;
            $display("FAIL %s multiplierReg: got %h required %h", name, multiplierReg, e.mr);
        end
        checks++;
        if (multiplierReg_t !== e.mr_t) begin
            errors++;
            $display("FAIL %s multiplierReg_t: got %h required %h", name, multiplierReg_t, e.mr_t);
        end
        $display("txn %s: product=%h product_t=%h mr=%h mr_t=%h", name, product, product_t,
                 multiplierReg, multiplierReg_t);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({product, product_t, multiplierReg, multiplierReg_t} !== '0) begin
            errors++;
            $display("FAIL %s: got product=%h product_t=%h mr=%h mr_t=%h required all 0",
                     name, product, product_t, multiplierReg, multiplierReg_t);
        end
        $display("txn %s: product=%h product_t=%h mr=%h mr_t=%h", name, product, product_t,
                 multiplierReg, multiplierReg_t);
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_strobes();
        multiplicand = 4'hF; multiplicand_t = 4'hF; multiplier = 4'hF; multiplier_t = 4'hF;
        mdld = 1; mrld = 1; rsload = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        clear_strobes();
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_basic();
        run_mult(4'd13, 4'h0, 4'd11, 4'h0, 8'h00);
        check_result("13x11");
        run_mult(4'd15, 4'h0, 4'd15, 4'h0, 8'h00);
        check_result("15x15");
        run_mult(4'd0, 4'h0, 4'd9, 4'h0, 8'h00);
        check_result("0x9");
    endtask

    task automatic test_mr_taint();
        run_mult(4'd6, 4'h0, 4'd4, 4'b0100, 8'h00);
        check_result("mr_taint");
    endtask

    task automatic test_load_taint();
        multiplicand = 4'd1; multiplicand_t = 4'b0001;
        multiplier = 4'd1;   multiplier_t = 4'b0000;
        mdld = 1; mrld = 1; rsclear = 1;
        step();
        rsload = 1;
        step();
        checks++;
        if (product_t !== 8'hF0 || product !== 8'h10) begin
            errors++;
            $display("FAIL load_taint: got product=%h product_t=%h required 10/f0", product, product_t);
        end
        $display("txn load_taint: product=%h product_t=%h", product, product_t);
        rsshr = 1;
        step();
        checks++;
        if (product_t !== 8'hF8 || product !== 8'h08) begin
            errors++;
            $display("FAIL shift_taint: got product=%h product_t=%h required 08/f8", product, product_t);
        end
        $display("txn shift_taint: product=%h product_t=%h", product, product_t);
    endtask

    task automatic test_ctrl_taint_kill();
        rsload_t = 1; mrld_t = 1;
        step();
        checks++;
        if (product !== 8'h08 || product_t !== 8'hFF || multiplierReg_t !== 4'hF ||
            multiplierReg !== 4'h1) begin
            errors++;
            $display("FAIL ctrl_taint: got product=%h product_t=%h mr=%h mr_t=%h required 08/ff/1/f",
                     product, product_t, multiplierReg, multiplierReg_t);
        end
        $display("txn ctrl_taint: product=%h product_t=%h mr_t=%h", product, product_t, multiplierReg_t);
        data_t_kill = 1; rsshr_t = 1; mdld_t = 1;
        step();
        checks++;
        if (product !== 8'h08 || product_t !== 8'h00 || multiplierReg_t !== 4'h0 ||
            multiplierReg !== 4'h1) begin
            errors++;
            $display("FAIL kill: got product=%h product_t=%h mr=%h mr_t=%h required 08/00/1/0",
                     product, product_t, multiplierReg, multiplierReg_t);
        end
        $display("txn kill: product=%h product_t=%h mr_t=%h", product, product_t, multiplierReg_t);
        // md_t is only observable through a later load into cleared rs.
        rsclear = 1;
        step();
        rsload = 1;
        step();
        checks++;
        if (product_t !== 8'h00 || product !== 8'h10) begin
            errors++;
            $display("FAIL md_t_killed: got product=%h product_t=%h required 10/00", product, product_t);
        end
        $display("txn md_t_killed: product=%h product_t=%h", product, product_t);
    endtask

    task automatic test_async_reset();
        start_mult(4'd9, 4'h0, 4'd7, 4'h0);
        rsload = 1;
        step();
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1;
        #1;
        run_mult(4'd3, 4'h0, 4'd5, 4'h0, 8'h00);
        check_result("3x5_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        for (int n = 0; n < 6; n++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            run_mult(a, 4'h0, b, 4'h0, 8'h00);
            check_result($sformatf("rand%0d_%0dx%0d", n, a, b));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mr_taint();
        test_load_taint();
        test_ctrl_taint_kill();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiplier_datapath_taint_track.md
Name: multiplier_datapath_taint_track

Overview:
- Shift-add datapath for the sequential multiplier. It is the responder to the multiplier controller's strobes (rsload, rsclear, rsshr, mrld, mdld and their taint bits).
- Holds the multiplicand, the multiplier and the running-sum registers. Returns the multiplier register and its taint to the controller, and presents the product and product taint.
- Applies conservative taint propagation on every register update, plus a synchronous taint kill.

Parameters:
- WIDTH, 1024, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- multiplicand  input  WIDTH  operand captured on mdld
- multiplicand_t  input  WIDTH  per-bit taint of multiplicand
- multiplier  input  WIDTH  operand captured on mrld
- multiplier_t  input  WIDTH  per-bit taint of multiplier
- rsload  input  1  add md into rs upper half
- rsload_t  input  1  taint of rsload
- rsclear  input  1  zero rs
- rsclear_t  input  1  taint of rsclear
- rsshr  input  1  shift rs right by one
- rsshr_t  input  1  taint of rsshr
- mrld  input  1  load multiplier register
- mrld_t  input  1  taint of mrld
- mdld  input  1  load multiplicand register
- mdld_t  input  1  taint of mdld
- data_t_kill  input  1  synchronous clear of all taint registers
- multiplierReg  output  WIDTH  mr register, to controller
- multiplierReg_t  output  WIDTH  mr taint, to controller
- product  output  2*WIDTH  rs[2*WIDTH-1:0]
- product_t  output  2*WIDTH  rs_t[2*WIDTH-1:0]

Behaviour:
- Registers:
  - md[WIDTH-1:0], mr[WIDTH-1:0], rs[2*WIDTH:0] (bit 2*WIDTH is the carry).
  - Each has a same-width taint register: md_t, mr_t, rs_t.
  - All outputs are direct register reads; no combinational path from inputs to outputs.
- Reset: rst_n=0 asynchronously clears md, mr, rs and all taint registers to 0. multiplierReg, multiplierReg_t, product and product_t therefore read 0. Reset mid-multiply discards the operation.
- mdld=1: md<=multiplicand; md_t<=multiplicand_t.
- mrld=1: mr<=multiplier; mr_t<=multiplier_t.
- mdld and mrld are independent of each other and of the rs strobes.
- rs priority, one action per cycle: rsclear > rsload > rsshr; hold if none is asserted.
  - rsclear: rs<=0; rs_t<=0.
  - rsload: rs[2*WIDTH:WIDTH] <= rs[2*WIDTH:WIDTH] + {1'b0,md}, WIDTH+1-bit sum with the carry landing in bit 2*WIDTH. Lower half unchanged.
  - rsload taint:
    - upper taint bit i = OR of (rs_t upper bits 0..i) and (md_t bits 0..min(i,WIDTH-1)), i.e. a prefix-OR carry-chain approximation.
    - lower taint unchanged.
  - rsshr: rs<=rs>>1 with 0 fill at the MSB. rs_t<=rs_t>>1 with 0 fill; taint moves with data.
- Control-taint rule (conservative): for each strobe whose _t=1, the destination's whole taint register becomes all-ones that cycle, regardless of strobe value.
  - mdld_t -> md_t; mrld_t -> mr_t.
  - Any of rsclear_t, rsload_t, rsshr_t -> rs_t.
  - The data update itself follows the strobe values.
- data_t_kill=1 (synchronous): every taint register <=0 that cycle, overriding all taint updates; data updates proceed normally.
- Operation:
  - Controller sequence is mdld+mrld+rsclear; then per bit, rsshr followed by rsload when mr[k]=1; WIDTH+1 shifts total, the first acting on zero.
  - product is valid the cycle after the final rsshr (controller productDone).
  - No overflow is possible: max product < 2^(2*WIDTH), and bit 2*WIDTH is 0 after the final shift.
- Latency: every strobe takes effect on the next posedge.

Test Plan:
- WIDTH=4, md=13, mr=11, controller strobe sequence, all taints 0 -> product=143 (8'h8F), product_t=0, multiplierReg=4'hB.
- WIDTH=4, md=15, mr=15 -> product=225 (8'hE1); carry bit exercised, rs[8]=0 at end.
- WIDTH=4, mr_t=4'b0100 at mrld, md_t=0 -> multiplierReg_t=4'b0100, product_t=0. Only the controller sees the taint.
- WIDTH=4, md=1, md_t=4'b0001, mr=4'b0001, clear, rsload -> rs_t[8:4]=5'b11111; after one rsshr, rs_t[7:3]=5'b11111, rs_t[8]=0.
- rsload_t=1 with rsload=0 -> rs data unchanged, rs_t all-ones. Next cycle data_t_kill=1 -> rs_t=0, md_t=0, mr_t=0, data intact.
- rst_n dropped asynchronously mid-multiply (between clock edges) -> all outputs 0 immediately. After rst_n rises, a fresh 3x5 sequence -> product=15.
